// File: rtl/cache_pkg.sv
// cache_pkg: shared refill FSM states, default line geometry and packed line type.
package cache_pkg;
   localparam int DEF_N_CACHELINE_LENGTH = 4;
   localparam int DEF_BITSIZE = 32;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} refill_state_t;
   typedef logic [DEF_N_CACHELINE_LENGTH-1:0][DEF_BITSIZE-1:0] line_t;
endpackage

// File: rtl/cache_refill_unit_if.sv
// cache_refill_unit_if: req/gnt/rvalid memory read bus between refill unit and memory.
interface cache_refill_unit_if #(parameter int BITSIZE = 32);
   logic mem_req_o;
   logic [BITSIZE-1:0] mem_addr_o;
   logic mem_gnt_i;
   logic mem_rvalid_i;
   logic [BITSIZE-1:0] mem_rdata_i;
   modport master(output mem_req_o, mem_addr_o, input mem_gnt_i, mem_rvalid_i, mem_rdata_i);
   modport slave(input mem_req_o, mem_addr_o, output mem_gnt_i, mem_rvalid_i, mem_rdata_i);
endinterface

// File: rtl/refill_line_buffer.sv
// refill_line_buffer: N-word line assembly registers with indexed write and clear.
module refill_line_buffer #(
   parameter int N = 4,
   parameter int W = 32,
   parameter int OW = $clog2(N)
) (
   input  logic clk,
   input  logic rstn_i,
   input  logic clr,
   input  logic we,
   input  logic [OW-1:0] idx,
   input  logic [W-1:0] wdata,
   output logic [N-1:0][W-1:0] line
);
   always_ff @(posedge clk or negedge rstn_i)
      if (!rstn_i) line <= '0;
      else if (clr) line <= '0;
      else if (we) line[idx] <= wdata;
endmodule

// File: rtl/cache_refill_unit.sv
// cache_refill_unit: i-cache miss handler fetching one line word by word, then strobing store_o.
// Define CRITICAL_WORD_FIRST_EN to fetch from the missed word with wrap and forward it early.
module cache_refill_unit import cache_pkg::*; #(
   parameter int N_CACHELINE_LENGTH = DEF_N_CACHELINE_LENGTH,
   parameter int BITSIZE = DEF_BITSIZE,
   parameter int OFFSET_W = $clog2(N_CACHELINE_LENGTH)
) (
   input  logic clk,
   input  logic rstn_i,
   input  logic miss_valid_i,
   input  logic [BITSIZE-1:0] miss_addr_i,
   output logic busy_o,
   cache_refill_unit_if.master mem,
   output logic [BITSIZE-1:0] line_addr_o,
   output logic [N_CACHELINE_LENGTH-1:0][BITSIZE-1:0] line_data_o,
   output logic store_o,
   output logic crit_valid_o,
   output logic [BITSIZE-1:0] crit_data_o
);
`ifdef CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif
   refill_state_t state;
   logic [OFFSET_W-1:0] cnt, start, start_in, idx, nidx;
   logic [BITSIZE-1:0] base, base_in;
   logic [N_CACHELINE_LENGTH-1:0][BITSIZE-1:0] buf_line, merged;
   logic wr;
   assign start_in = CWF ? miss_addr_i[OFFSET_W-1:0] : '0;
   assign base_in = {miss_addr_i[BITSIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
   assign idx = start + cnt;
   assign nidx = idx + 1'b1;
   assign wr = state == WAIT && mem.mem_rvalid_i;
   assign busy_o = state != IDLE;
   // the final word lands in the buffer on the same edge the line is published
   always_comb begin
      merged = buf_line;
      merged[idx] = mem.mem_rdata_i;
   end
   refill_line_buffer #(.N(N_CACHELINE_LENGTH), .W(BITSIZE), .OW(OFFSET_W)) u_buf (
      .clk(clk), .rstn_i(rstn_i), .clr(state == IDLE && miss_valid_i), .we(wr),
      .idx(idx), .wdata(mem.mem_rdata_i), .line(buf_line)
   );
   always_ff @(posedge clk or negedge rstn_i)
      if (!rstn_i) begin
         state <= IDLE;
         cnt <= '0;
         start <= '0;
         base <= '0;
         mem.mem_req_o <= 1'b0;
         mem.mem_addr_o <= '0;
         store_o <= 1'b0;
         line_addr_o <= '0;
         line_data_o <= '0;
      end else begin
         store_o <= 1'b0;
         case (state)
            IDLE: if (miss_valid_i) begin
               base <= base_in;
               start <= start_in;
               cnt <= '0;
               mem.mem_req_o <= 1'b1;
               mem.mem_addr_o <= base_in | BITSIZE'(start_in);
               state <= REQ;
            end
            REQ: if (mem.mem_gnt_i) begin
               mem.mem_req_o <= 1'b0;
               state <= WAIT;
            end
            WAIT: if (mem.mem_rvalid_i) begin
               if (cnt == OFFSET_W'(N_CACHELINE_LENGTH - 1)) begin
                  store_o <= 1'b1;
                  line_addr_o <= base;
                  line_data_o <= merged;
                  state <= WRITE;
               end else begin
                  cnt <= cnt + 1'b1;
                  mem.mem_req_o <= 1'b1;
                  mem.mem_addr_o <= base | BITSIZE'(nidx);
                  state <= REQ;
               end
            end
            WRITE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
`ifdef CRITICAL_WORD_FIRST_EN
   always_ff @(posedge clk or negedge rstn_i)
      if (!rstn_i) begin
         crit_valid_o <= 1'b0;
         crit_data_o <= '0;
      end else begin
         crit_valid_o <= wr && cnt == '0;
         if (wr && cnt == '0) crit_data_o <= mem.mem_rdata_i;
      end
`else
   assign crit_valid_o = 1'b0;
   assign crit_data_o = '0;
`endif
endmodule

// File: doc/cache_refill_unit.md
Name: cache_refill_unit

Overview:
- Miss handler placed directly upstream of the cache line storage in the core's instruction-cache path.
- On a miss it latches the address and fetches N_CACHELINE_LENGTH words from memory, one outstanding request at a time, over a req/gnt/rvalid bus.
- It assembles the words into a full line, then pulses store_o with the line-aligned address and the packed line. The cache line consumes these on its store inputs.

Parameters:
- N_CACHELINE_LENGTH, 4, words per line; power of two, at least 2.
- BITSIZE, 32, word and address width; addresses are word addresses.
- OFFSET_W, $clog2(N_CACHELINE_LENGTH), word-offset width inside a line.

Ports:
- clk  in  1  clock; rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- miss_valid_i  in  1  miss request; sampled only in IDLE.
- miss_addr_i  in  BITSIZE  word address that missed.
- busy_o  out  1  high in every state except IDLE.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  BITSIZE  word address of the current request.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  BITSIZE  read data.
- line_addr_o  out  BITSIZE  miss address with the low OFFSET_W bits cleared.
- line_data_o  out  BITSIZE*N_CACHELINE_LENGTH  packed line; word k sits at bits [(k+1)*BITSIZE-1 : k*BITSIZE].
- store_o  out  1  one-cycle write strobe to the cache line.
- crit_valid_o  out  1  critical-word forward strobe (see Optional Feature).
- crit_data_o  out  BITSIZE  critical-word data.

Behaviour:
- Reset (async assert, deasserted synchronously by the system):
  - FSM goes to IDLE.
  - All outputs go to 0; line buffer is cleared; counters are cleared.
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE:
  - busy_o = 0.
  - On miss_valid_i: latch miss_addr_i; set start offset (0, or the miss offset when the optional feature is on); clear word counter cnt; go to REQ.
- REQ:
  - mem_req_o = 1.
  - mem_addr_o = line base | ((start + cnt) mod N); the mod is the natural OFFSET_W-bit wrap.
  - mem_req_o and mem_addr_o are held stable until mem_gnt_i.
  - On mem_gnt_i, go to WAIT.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i, write mem_rdata_i into line slot (start + cnt) mod N.
  - If cnt == N-1, go to WRITE; otherwise increment cnt and go to REQ.
- WRITE:
  - store_o = 1 for exactly one cycle; line_addr_o and line_data_o are valid in that cycle.
  - Next state is IDLE.
  - line_data_o and line_addr_o hold their values until the next WRITE.
- Latency: with gnt in the same cycle as req and rvalid the following cycle, store_o rises 2N+1 cycles after the cycle miss_valid_i is sampled. For N = 4 that is 9 cycles.
- Ignored inputs:
  - mem_rvalid_i outside WAIT.
  - mem_gnt_i outside REQ.
  - miss_valid_i outside IDLE.
- Back-to-back misses: a new miss is accepted in the IDLE cycle after WRITE, so there is a minimum 1-cycle bubble between refills.
- Reset mid-refill:
  - mem_req_o drops immediately and the partial line is discarded.
  - No store_o is issued.
  - A late rvalid arriving after reset is ignored, because the FSM is in IDLE.
- Only one request is ever outstanding; no error or abort path exists.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - start = miss_addr_i[OFFSET_W-1:0].
  - Requests wrap from the missed word through the end of the line and back to offset 0.
  - In the cycle after the first rvalid, crit_valid_o pulses for one cycle with crit_data_o = that word.
  - The final line contents are identical to the non-feature case.
- Undefined:
  - start = 0, so requests run in ascending order.
  - crit_valid_o and crit_data_o are tied to 0. Ports exist in both builds.

Decomposition:
- Shared package cache_pkg holds:
  - the refill_state_t enum (IDLE, REQ, WAIT, WRITE);
  - the default N_CACHELINE_LENGTH and BITSIZE constants;
  - the line_t packed-line typedef, shared with the cache line.
- One sub-module, refill_line_buffer: an N-word register array with a write enable, an OFFSET_W-bit write index and a clear input, and a packed line output.

Test Plan:
- Basic refill: N=4, no feature, miss 0x13; gnt immediate, rvalid next cycle, data 0xA0..0xA3.
  -> mem_addr_o sequence 0x10, 0x11, 0x12, 0x13.
  -> store_o at cycle 9, line_addr_o = 0x10, line_data_o = {0xA3, 0xA2, 0xA1, 0xA0}.
- Grant stall: gnt withheld 3 cycles on the second word.
  -> mem_req_o = 1 and mem_addr_o = 0x11 held stable throughout.
  -> store_o moves to cycle 12.
- Critical word first (CRITICAL_WORD_FIRST_EN), miss 0x13.
  -> addresses 0x13, 0x10, 0x11, 0x12.
  -> crit_valid_o pulses at cycle 3 with the word for 0x13.
  -> line packed by offset, identical to the basic refill case.
- Reset mid-refill: rstn_i low during WAIT after 2 words, then a stray rvalid.
  -> all outputs 0 immediately, no store_o.
  -> the next miss at 0x20 refills cleanly.
- Sustained miss request: miss_valid_i held high throughout.
  -> exactly one refill per IDLE entry.
  -> second refill starts the cycle after store_o; busy_o low for exactly that 1 cycle.
